// File: rtl/tour_cmd_pkg.sv
// tour_cmd_pkg: shared states, error codes and KnightsTour command fields for the command player
package tour_cmd_pkg;
  typedef enum logic [2:0] {IDLE, SEND, WAIT_SNT, WAIT_RESP, CHECK, FINISH} state_t;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_NAK = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;
  localparam logic [7:0] ACK_DEFAULT = 8'hA5;
  // Command layout: [15:12] opcode, [11:4] heading, [3:0] squares
  localparam logic [3:0] CAL_GYRO = 4'h2;
  localparam logic [3:0] MOVE = 4'h4;
  localparam logic [3:0] MOVE_FANFARE = 4'h5;
  localparam logic [7:0] NORTH = 8'h00;
  localparam logic [7:0] WEST = 8'h3F;
  localparam logic [7:0] SOUTH = 8'h7F;
  localparam logic [7:0] EAST = 8'hBF;
endpackage

// File: rtl/tour_cmd_player_cmd_buf.sv
// cmd_buf: DEPTH x CMD_W command store filled in order, with an occupancy count
module cmd_buf #(
  parameter int CMD_W = 16,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             clr,
  input  logic [AW-1:0]    rd_idx,
  input  logic [CMD_W-1:0] wr_data,
  output logic [CMD_W-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full
);
  logic [CMD_W-1:0] mem [DEPTH];
  assign full = count == CW'(DEPTH);
  assign rd_data = mem[rd_idx];
  always_ff @(posedge clk)
    if (wr_en && !full && !clr) mem[count[AW-1:0]] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else count <= clr ? '0 : (wr_en && !full) ? count + CW'(1) : count;
endmodule

// File: rtl/tour_cmd_player.sv
// tour_cmd_player: replays buffered KnightsTour commands into RemoteComm and checks each response
module tour_cmd_player
  import tour_cmd_pkg::*;
#(
  parameter int CMD_W = 16,
  parameter int RESP_W = 8,
  parameter int DEPTH = 16,
  parameter logic [RESP_W-1:0] ACK_VAL = RESP_W'(ACK_DEFAULT),
  parameter int TIMEOUT_CLKS = 2000000,
  parameter int CNT_W = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CMD_W-1:0]  wr_data,
  input  logic              clr,
  input  logic              start,
  input  logic              abort,
  input  logic              mode_loop,
  input  logic              stop_on_err,
  output logic [CMD_W-1:0]  cmd,
  output logic              snd_cmd,
  input  logic              cmd_snt,
  input  logic              resp_rdy,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [AW-1:0]     cmd_idx,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt
);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  state_t st, nxt;
  logic [CMD_W-1:0] rd_data;
  logic [RESP_W-1:0] resp_q;
  logic [TW-1:0] timer;
  logic waiting, tmo, last, nak;
  assign waiting = st == WAIT_SNT || st == WAIT_RESP;
  // >= so a cmd_snt on the final budget cycle still times out in WAIT_RESP
  assign tmo = timer >= TW'(TIMEOUT_CLKS - 1);
  assign last = CW'(cmd_idx) == count - CW'(1);
  assign nak = resp_q != ACK_VAL;
  cmd_buf #(.CMD_W(CMD_W), .DEPTH(DEPTH)) u_buf (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en && st == IDLE && !start),
    .clr(clr && st == IDLE && !start),
    .rd_idx(cmd_idx),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .count(count),
    .full(full)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:      nxt = !start ? IDLE : count == '0 ? FINISH : SEND;
      SEND:      nxt = WAIT_SNT;
      WAIT_SNT:  nxt = cmd_snt ? WAIT_RESP : tmo ? FINISH : WAIT_SNT;
      WAIT_RESP: nxt = resp_rdy ? CHECK : tmo ? FINISH : WAIT_RESP;
      CHECK:     nxt = (nak && stop_on_err) || (last && !mode_loop) ? FINISH : SEND;
      FINISH:    nxt = IDLE;
      default:   nxt = IDLE;
    endcase
    if (abort && st != IDLE) nxt = IDLE;
  end
  always_comb begin
    snd_cmd = st == SEND;
    busy = st != IDLE;
    done = st == FINISH;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cmd <= '0;
      cmd_idx <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      err <= 1'b0;
      err_code <= ERR_NONE;
      resp_q <= '0;
      timer <= '0;
    end else begin
      if (st == IDLE && start) begin
        cmd_idx <= '0;
        pass_cnt <= '0;
        fail_cnt <= '0;
        err <= 1'b0;
        err_code <= ERR_NONE;
      end
      if (st == SEND) begin
        cmd <= rd_data;
        timer <= '0;
      end
      if (waiting) timer <= timer + TW'(1);
      if (st == WAIT_RESP && resp_rdy) resp_q <= resp;
      // Leaving a wait state for FINISH can only mean the budget ran out
      if (waiting && nxt == FINISH) begin
        err <= 1'b1;
        err_code <= ERR_TMO;
      end
      if (st == CHECK) begin
        if (nak) begin
          fail_cnt <= fail_cnt + CNT_W'(fail_cnt != '1);
          err <= 1'b1;
          err_code <= err_code == ERR_TMO ? ERR_TMO : ERR_NAK;
        end else pass_cnt <= pass_cnt + CNT_W'(pass_cnt != '1);
        if (nxt == SEND) cmd_idx <= last ? '0 : cmd_idx + AW'(1);
      end
    end
endmodule
